axis_sync_fifo: RTL and testbench
=================================

AXIS_SYNC_FIFO -- requirements
Module: axis_sync_fifo

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, log2 of FIFO depth (DEPTH = 2**ADDR_WIDTH = 16 entries); first positional parameter.
REQ-002 Parameter DATA_WIDTH, default 256, tdata width in bits; second positional parameter.
REQ-003 Port order SHALL be exactly rst, clk, s_axis_tvalid, s_axis_tready, s_axis_tdata, m_axis_tdata, m_axis_tvalid, m_axis_tready, so positional instantiation works.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 s_axis_tvalid  input  1  upstream word valid.
REQ-007 s_axis_tready  output  1  FIFO can accept a word.
REQ-008 s_axis_tdata  input  DATA_WIDTH  upstream word.
REQ-009 m_axis_tdata  output  DATA_WIDTH  head-of-FIFO word.
REQ-010 m_axis_tvalid  output  1  FIFO holds at least one word.
REQ-011 m_axis_tready  input  1  downstream accepts head word.

Function
REQ-012 Storage: DEPTH x DATA_WIDTH array, write pointer and read pointer of ADDR_WIDTH+1 bits each (extra wrap bit).
REQ-013 Empty when pointers are equal; full when low ADDR_WIDTH bits are equal and wrap bits differ.
REQ-014 Capacity SHALL be exactly DEPTH words.
REQ-015 s_axis_tready = not full, and SHALL be low while rst is low; derived from registered state only (no combinational path from m_axis_tready or any s_axis input).
REQ-016 m_axis_tvalid = not empty; registered-state derived, no combinational path from any s_axis input.
REQ-017 Write: when s_axis_tvalid and s_axis_tready are high at a rising edge, store s_axis_tdata at mem[wr_ptr] and increment wr_ptr by 1, modulo 2**(ADDR_WIDTH+1).
REQ-018 Read: when m_axis_tvalid and m_axis_tready are high at a rising edge, increment rd_ptr by 1, modulo 2**(ADDR_WIDTH+1).
REQ-019 m_axis_tdata = mem[rd_ptr low bits].
  - Stable while m_axis_tvalid is high and m_axis_tready is low.
  - Don't-care while m_axis_tvalid is low.
REQ-020 Latency: a word accepted into an empty FIFO at edge N SHALL appear with m_axis_tvalid high in the cycle after edge N.
REQ-021 Simultaneous write and read in the same cycle (not empty, not full): both SHALL occur; occupancy unchanged; order preserved.
REQ-022 Simultaneous events at the limits:
  - Full: s_axis_tready is low, so no write, even if a read occurs that cycle; tready rises the cycle after the read.
  - Empty: no read, because m_axis_tvalid is low.
REQ-023 Words SHALL leave in exact arrival order, with no loss or duplication, across pointer wrap-around.
REQ-024 Data and valid on each side are independent; no other internal state machine beyond the pointers.

Reset
REQ-025 At a rising edge with rst low: wr_ptr and rd_ptr set to 0.
REQ-026 From the next cycle after that reset edge (FIFO empty): m_axis_tvalid = 0; s_axis_tready = 1 once rst is high.
REQ-027 Reset SHALL NOT clear memory contents; m_axis_tdata is don't-care after reset.
REQ-028 Reset mid-operation SHALL discard all stored words; the first word written after reset is the first word read.
REQ-029 Initial (pre-reset) register state SHALL equal the reset state.

Verification
REQ-030 Reset, then idle -> m_axis_tvalid=0, s_axis_tready=1.
REQ-031 Write 0x1 with m_axis_tready=0 -> next cycle m_axis_tvalid=1, m_axis_tdata=0x1, held across 5 stall cycles.
REQ-032 Write 16 words 0x0..0xF with m_axis_tready=0:
  - s_axis_tready drops after the 16th accept.
  - A 17th word (0xAA) offered with tvalid held is not accepted.
  - One read then frees a slot: 0xAA is accepted and later read last.
REQ-033 Continuous stream of 40 incrementing words with tvalid=tready=1 on both sides -> output sequence 0..39 in order, no gaps after first-word latency, pointers wrap correctly.
REQ-034 Random tvalid/tready toggling for 1000 words -> scoreboard matches exactly, never more than 16 stored.
REQ-035 Fill 5 words, assert rst low for one edge -> m_axis_tvalid=0. Then write 0x55 -> 0x55 is the next word output.

Source files
------------

// File: rtl/axis_sync_fifo.sv
// AXI-Stream synchronous FIFO, DEPTH = 2**ADDR_WIDTH words.
// Extra pointer wrap bit distinguishes full from empty.
module axis_sync_fifo #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_INC =
    (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Power-up value matches the reset value.
  logic [ADDR_WIDTH:0] r_wr_ptr = '0;
  logic [ADDR_WIDTH:0] r_rd_ptr = '0;

  logic w_empty;
  logic w_full;
  logic w_wr;
  logic w_rd;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  =
    (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
    (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

  assign s_axis_tready = rst && !w_full;
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

  assign w_wr = s_axis_tvalid && s_axis_tready;
  assign w_rd = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_INC;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_INC;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= s_axis_tdata;
  end

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Scoreboard bench for axis_sync_fifo.
// Inputs change after posedge; everything sampled at negedge.
module tb_axis_sync_fifo;

  localparam int AW = 4;
  localparam int DW = 256;
  localparam int DEPTH = 16;

  logic          rst;
  logic          clk;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;

  axis_sync_fifo #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) u_dut (
    .rst          (rst),
    .clk          (clk),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  logic [DW-1:0] q[$];
  int            occ = 0;
  int            pops = 0;
  int            cyc = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  logic [DW-1:0] first_val = '0;
  logic [DW-1:0] last_val = '0;

  always @(negedge clk) begin
    logic [DW-1:0] e;
    cyc++;
    if (!rst) begin
      chk("rst_s_tready", s_tready, 1'b0);
      q.delete();
      occ = 0;
    end else begin
      chk("s_tready", s_tready, occ < DEPTH);
      chk("m_tvalid", m_tvalid, occ != 0);
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) begin
          chk("pop_empty", q.size(), 1);
        end else begin
          e = q.pop_front();
          chk("data", m_tdata, e);
          pops++;
          if (pops == 1) begin
            first_cyc = cyc;
            first_val = e;
          end
          last_cyc = cyc;
          last_val = e;
          occ--;
        end
      end
      if (s_tvalid && s_tready) begin
        q.push_back(s_tdata);
        occ++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int  n;
    logic ok;
    n = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      ok = s_tready;
      tick();
      if (ok) break;
      n++;
      if (n > 500) begin
        chk("send_timeout", n, 0);
        break;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_tready = 1'b1;
    while (occ != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("drain_left", occ, 0);
    m_tready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // idle after reset
    repeat (2) tick();
    @(negedge clk);
    chk("idle_tvalid", m_tvalid, 1'b0);
    chk("idle_tready", s_tready, 1'b1);
    tick();

    // single word held across stalls
    send(256'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_tvalid", m_tvalid, 1'b1);
      chk("stall_data", m_tdata, 256'h1);
      tick();
    end
    drain();

    // fill to capacity, 17th held off
    for (int i = 0; i < DEPTH; i++) send(DW'(i));
    @(negedge clk);
    chk("full_tready", s_tready, 1'b0);
    chk("full_occ", occ, DEPTH);
    tick();
    s_tdata  = 256'hAA;
    s_tvalid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("aa_blocked", occ, DEPTH);
    tick();
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    @(negedge clk);
    chk("slot_free", s_tready, 1'b1);
    tick();
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("refill_occ", occ, DEPTH);
    tick();
    drain();
    chk("aa_last", last_val, 256'hAA);

    // back-to-back stream
    pops = 0;
    m_tready = 1'b1;
    for (int i = 0; i < 40; i++) send(DW'(i));
    repeat (4) tick();
    chk("stream_pops", pops, 40);
    chk("stream_span", last_cyc - first_cyc, 39);
    chk("stream_last", last_val, DW'(39));
    m_tready = 1'b0;

    // random handshakes
    pops = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          send({$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom});
        end
      end
      begin
        int n;
        n = 0;
        while (pops < 1000 && n < 20000) begin
          m_tready = 1'($urandom_range(0, 1));
          tick();
          n++;
        end
        m_tready = 1'b0;
      end
    join
    chk("rand_pops", pops, 1000);

    // reset mid-operation
    for (int i = 0; i < 5; i++) send(DW'(32'hC0 + i));
    do_reset();
    @(negedge clk);
    chk("mid_rst_tvalid", m_tvalid, 1'b0);
    tick();
    pops = 0;
    send(256'h55);
    drain();
    chk("post_rst_first", first_val, 256'h55);
    chk("post_rst_pops", pops, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
